minilab0_arb: RTL and testbench
===============================

MINILAB0_ARB -- requirements
Module: minilab0_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, lookup address width.
REQ-002 SHALL have parameter DATA_W, default 8, lookup data width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  requester N has a lookup pending.
REQ-006 SHALL have ports req0_addr / req1_addr  input  ADDR_W  requester N lookup address.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1  request N accepted this cycle.
REQ-008 SHALL have ports resp0_valid / resp1_valid  output  1  response N data valid.
REQ-009 SHALL have ports resp0_data / resp1_data  output  DATA_W  response N lookup result.
REQ-010 SHALL have ports resp0_ready / resp1_ready  input  1  requester N consumes the response.
REQ-011 SHALL have port lut_en  output  1  lookup-table enable.
REQ-012 SHALL have port lut_addr  output  ADDR_W  lookup-table address.
REQ-013 SHALL have port lut_data  input  DATA_W  registered lookup-table output, valid one cycle after lut_en.
REQ-014 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, READ, WAIT, RESP; one transaction in flight at a time.
REQ-016 IDLE: if any reqN_valid, SHALL assert reqN_ready combinationally for the granted requester only, latch its address and grant ID, and go to READ; else stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it unconditionally.
REQ-018 The last-grant pointer SHALL update only on acceptance (valid & ready).
REQ-019 READ: SHALL drive lut_en=1 and lut_addr=latched address for exactly one cycle, then go to WAIT.
REQ-020 WAIT: SHALL capture lut_data into the response register at the end of the cycle, then go to RESP.
REQ-021 RESP: SHALL hold respN_valid=1 and respN_data stable for the granted N until respN_ready=1; on that edge SHALL return to IDLE.
REQ-022 Latency: if acceptance is in cycle 0, respN_valid SHALL first be high in cycle 3; if resp ready is already high, the next acceptance SHALL occur no earlier than cycle 4.
REQ-023 Outside READ, lut_en SHALL be 0 and lut_addr SHALL be 0.
REQ-024 reqN_ready SHALL be 0 in every state except IDLE; the non-granted requester's ready and resp_valid SHALL stay 0.
REQ-025 resp_data of the non-granted port SHALL be 0; respN_ready outside RESP SHALL be ignored.
REQ-026 A reqN_valid dropped before acceptance SHALL have no effect; requesters are required to hold addr stable while valid.
REQ-027 Address and data SHALL pass through unmodified, with no width conversion.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, last-grant=requester 1 (so requester 0 wins the first tie), and all outputs to 0.
REQ-029 Reset mid-transaction SHALL drop the in-flight lookup with no response issued; after release, operation SHALL start from IDLE.

Structure
REQ-030 The state enum, the requester-ID type, and the ADDR_W/DATA_W defaults SHALL reside in shared package minilab_pkg.
REQ-031 The round-robin grant logic SHALL be a sub-module rr_pick2 (inputs: two valids, last-grant; outputs: grant valid, grant ID).

Verification
REQ-032 With the bench connecting the 8-entry minilab0 lookup table, req0 addr 0x80 alone, resp0_ready=1 -> resp0_data=0xAA in cycle 3; resp1_valid stays 0.
REQ-033 req0 addr 0x40 and req1 addr 0x04 raised simultaneously after reset -> req0 served first (0x02), then req1 (0x0F).
REQ-034 Both requesters continuously valid for 4 transactions -> grants alternate 0,1,0,1.
REQ-035 req1 addr 0x10 with resp1_ready low for 5 cycles -> resp1_valid/0xFF held stable, busy=1, no new acceptance; then ready=1 -> IDLE.
REQ-036 Unmapped addr 0x03 -> resp_data=0x00; rst_n pulsed low during WAIT -> all outputs 0 immediately, no response issued.
REQ-037 lut_en SHALL be observed high exactly once per transaction in every scenario.

Source files
------------

// File: rtl/minilab_pkg.sv
// Shared types and width defaults for the minilab lookup arbiter slice.
package minilab_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/minilab0_arb_rr_pick2.sv
// Two-way round-robin pick: a tie goes to the requester not granted last.
module rr_pick2
    import minilab_pkg::*;
(
    input  logic    i_valid0,
    input  logic    i_valid1,
    input  req_id_t i_last,
    output logic    o_gnt_valid,
    output req_id_t o_gnt_id
);

    always_comb begin
        o_gnt_valid = i_valid0 | i_valid1;
        if (i_valid0 && i_valid1) begin
            o_gnt_id = ~i_last;
        end else if (i_valid1) begin
            o_gnt_id = REQ1;
        end else begin
            o_gnt_id = REQ0;
        end
    end

endmodule

// File: rtl/minilab0_arb.sv
// Arbitrates two requesters onto one registered lookup table, one
// transaction in flight: IDLE -> READ -> WAIT -> RESP -> IDLE.
module minilab0_arb
    import minilab_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_data,
    input  logic              resp0_ready,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_data,
    input  logic              resp1_ready,
    output logic              lut_en,
    output logic [ADDR_W-1:0] lut_addr,
    input  logic [DATA_W-1:0] lut_data,
    output logic              busy
);

    state_t            r_state;
    state_t            w_next;
    req_id_t           r_last;
    req_id_t           r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              w_gnt_valid;
    req_id_t           w_gnt_id;
    logic              w_accept;

    rr_pick2 u_pick (
        .i_valid0    (req0_valid),
        .i_valid1    (req1_valid),
        .i_last      (r_last),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_id    (w_gnt_id)
    );

    assign busy = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_last  <= REQ1;
            r_id    <= REQ0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_last <= w_gnt_id;
                r_id   <= w_gnt_id;
                r_addr <= (w_gnt_id == REQ1) ? req1_addr : req0_addr;
            end
            if (r_state == ST_WAIT) begin
                r_data <= lut_data;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        resp0_data  = '0;
        resp1_data  = '0;
        lut_en      = 1'b0;
        lut_addr    = '0;
        case (r_state)
            ST_IDLE: begin
                // Ready is combinational from valid, so hold it low while reset is asserted.
                if (rst_n && w_gnt_valid) begin
                    w_accept   = 1'b1;
                    req0_ready = (w_gnt_id == REQ0);
                    req1_ready = (w_gnt_id == REQ1);
                    w_next     = ST_READ;
                end
            end
            ST_READ: begin
                lut_en   = 1'b1;
                lut_addr = r_addr;
                w_next   = ST_WAIT;
            end
            ST_WAIT: begin
                w_next = ST_RESP;
            end
            ST_RESP: begin
                if (r_id == REQ0) begin
                    resp0_valid = 1'b1;
                    resp0_data  = r_data;
                    if (resp0_ready) begin
                        w_next = ST_IDLE;
                    end
                end else begin
                    resp1_valid = 1'b1;
                    resp1_data  = r_data;
                    if (resp1_ready) begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_minilab0_arb.sv
// Bench for minilab0_arb: vector table, corner sequences, and a randomized
// run against a transaction-level timing model.
`timescale 1ns/1ps
module tb_minilab0_arb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_addr = '0, req1_addr = '0;
    logic       req0_ready, req1_ready;
    logic       resp0_valid, resp1_valid;
    logic [7:0] resp0_data, resp1_data;
    logic       resp0_ready = 1'b0, resp1_ready = 1'b0;
    logic       lut_en;
    logic [7:0] lut_addr;
    logic [7:0] lut_data = '0;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int lut_cnt  = 0;

    minilab0_arb #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_addr   (req0_addr),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_addr   (req1_addr),
        .req1_ready  (req1_ready),
        .resp0_valid (resp0_valid),
        .resp0_data  (resp0_data),
        .resp0_ready (resp0_ready),
        .resp1_valid (resp1_valid),
        .resp1_data  (resp1_data),
        .resp1_ready (resp1_ready),
        .lut_en      (lut_en),
        .lut_addr    (lut_addr),
        .lut_data    (lut_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // 8-entry lookup table; unmapped addresses read as zero.
    function automatic logic [7:0] lut_fn(input logic [7:0] a);
        case (a)
            8'h80:   return 8'hAA;
            8'h40:   return 8'h02;
            8'h20:   return 8'hC3;
            8'h10:   return 8'hFF;
            8'h08:   return 8'h81;
            8'h04:   return 8'h0F;
            8'h02:   return 8'h3C;
            8'h01:   return 8'h5A;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) if (lut_en) lut_data <= lut_fn(lut_addr);
    always @(negedge clk) if (lut_en) lut_cnt <= lut_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [29:0] all_outs();
        return {req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_data,
                resp1_data, lut_en, lut_addr, busy};
    endfunction

    // Entered and left at posedge+1.
    task automatic apply_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_addr = '0; req1_addr = '0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        #1;
        chk("reset_outputs", 32'(all_outs()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit         do_rst;
        bit         v0;
        logic [7:0] a0;
        bit         v1;
        logic [7:0] a1;
        bit         exp_id;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v);
        logic [7:0] ea;
        int         c0;
        if (v.do_rst) apply_reset();
        c0 = lut_cnt;
        ea = v.exp_id ? v.a1 : v.a0;
        req0_valid = v.v0; req0_addr = v.a0;
        req1_valid = v.v1; req1_addr = v.a1;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        @(negedge clk);
        chk("vec_ready", {req0_ready, req1_ready}, v.exp_id ? 2'b01 : 2'b10);
        chk("vec_idle_busy", busy, 1'b0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_addr = '0; req1_addr = '0;
        @(negedge clk);
        chk("vec_lut", {lut_en, lut_addr}, {1'b1, ea});
        @(negedge clk);
        chk("vec_no_early_resp", {resp0_valid, resp1_valid, lut_en}, 3'b000);
        @(negedge clk);
        chk("vec_resp_valid", {resp0_valid, resp1_valid}, v.exp_id ? 2'b01 : 2'b10);
        chk("vec_resp_data", v.exp_id ? resp1_data : resp0_data, v.exp_data);
        chk("vec_other_data", v.exp_id ? resp0_data : resp1_data, 8'h00);
        @(posedge clk); #1;
        chk("vec_lut_once", lut_cnt - c0, 1);
    endtask

    int         gid[$];
    int         gcyc[$];
    logic [7:0] tbl[8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

    function automatic logic [7:0] pick_addr();
        logic [7:0] a;
        if ($urandom_range(0, 3) == 0) a = 8'($urandom);
        else a = tbl[$urandom_range(0, 7)];
        return a;
    endfunction

    // Transaction-level model state for the randomized run.
    bit         pend, m_id, m_last, g, exp_acc, exp_rv, acc0, acc1;
    int         acc_cyc, n_txn;
    logic [7:0] m_addr, m_data;

    initial begin
        vecs[0] = '{1'b1, 1'b1, 8'h80, 1'b0, 8'h00, 1'b0, 8'hAA};
        vecs[1] = '{1'b1, 1'b1, 8'h40, 1'b1, 8'h04, 1'b0, 8'h02};
        vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 8'h0F};
        vecs[3] = '{1'b0, 1'b1, 8'h03, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h10, 1'b1, 8'hFF};
        vecs[5] = '{1'b0, 1'b1, 8'h20, 1'b1, 8'h08, 1'b0, 8'hC3};
        vecs[6] = '{1'b0, 1'b1, 8'h20, 1'b1, 8'h08, 1'b1, 8'h81};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 8'h5A};

        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Both requesters held valid: grants alternate, four cycles apart.
        apply_reset();
        req0_valid = 1'b1; req0_addr = 8'h40;
        req1_valid = 1'b1; req1_addr = 8'h04;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        for (int c = 0; c < 40 && gid.size() < 4; c++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) begin gid.push_back(0); gcyc.push_back(c); end
            else if (req1_valid && req1_ready) begin gid.push_back(1); gcyc.push_back(c); end
            if (gid.size() < 4) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("alt_count", gid.size(), 4);
        for (int i = 0; i < gid.size(); i++) chk("alt_order", gid[i], i % 2);
        for (int i = 1; i < gcyc.size(); i++) chk("alt_spacing", gcyc[i] - gcyc[i-1], 4);
        repeat (4) @(posedge clk); #1;

        // Backpressured response holds and blocks further acceptance.
        req1_valid = 1'b1; req1_addr = 8'h10; resp1_ready = 1'b0; resp0_ready = 1'b0;
        @(negedge clk);
        chk("bp_accept", {req0_ready, req1_ready}, 2'b01);
        @(posedge clk); #1;
        req1_valid = 1'b0; req0_valid = 1'b1; req0_addr = 8'h80;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", {resp0_valid, resp1_valid, resp1_data, busy, req0_ready},
                {2'b01, 8'hFF, 1'b1, 1'b0});
        end
        @(posedge clk); #1;
        resp1_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", {resp1_valid, resp1_data}, {1'b1, 8'hFF});
        @(negedge clk);
        chk("bp_back_idle", {busy, resp1_valid, req0_ready}, 3'b001);
        @(posedge clk); #1;
        req0_valid = 1'b0; resp0_ready = 1'b1;
        repeat (4) @(posedge clk); #1;

        // Reset pulsed while the lookup is in WAIT.
        req0_valid = 1'b1; req0_addr = 8'h80; resp0_ready = 1'b1;
        @(negedge clk);
        chk("rstw_accept", {req0_ready, req1_ready}, 2'b10);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        chk("rstw_busy", busy, 1'b1);
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rstw_no_resp", {resp0_valid, resp1_valid, busy, lut_en}, 4'b0000);
        end
        @(posedge clk); #1;

        // Randomized traffic against the timing model.
        apply_reset();
        pend = 1'b0; m_last = 1'b1; m_id = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
        acc_cyc = 0; n_txn = 0; m_addr = '0; m_data = '0;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            if (acc0 || !req0_valid) begin
                if ($urandom_range(0, 2) == 0) begin req0_valid = 1'b1; req0_addr = pick_addr(); end
                else begin req0_valid = 1'b0; req0_addr = '0; end
            end else if ($urandom_range(0, 15) == 0) begin
                req0_valid = 1'b0; req0_addr = '0;
            end
            if (acc1 || !req1_valid) begin
                if ($urandom_range(0, 2) == 0) begin req1_valid = 1'b1; req1_addr = pick_addr(); end
                else begin req1_valid = 1'b0; req1_addr = '0; end
            end else if ($urandom_range(0, 15) == 0) begin
                req1_valid = 1'b0; req1_addr = '0;
            end
            resp0_ready = ($urandom_range(0, 3) != 0);
            resp1_ready = ($urandom_range(0, 3) != 0);

            @(negedge clk);
            exp_acc = !pend && (req0_valid || req1_valid);
            g = (req0_valid && req1_valid) ? ~m_last : req1_valid;
            chk("rnd_ready", {req0_ready, req1_ready}, exp_acc ? (g ? 2'b01 : 2'b10) : 2'b00);
            chk("rnd_lut", {lut_en, lut_addr},
                (pend && cyc == acc_cyc + 1) ? {1'b1, m_addr} : 9'd0);
            chk("rnd_busy", busy, pend);
            exp_rv = pend && (cyc >= acc_cyc + 3);
            chk("rnd_resp_valid", {resp0_valid, resp1_valid},
                exp_rv ? (m_id ? 2'b01 : 2'b10) : 2'b00);
            chk("rnd_resp0_data", resp0_data, (exp_rv && !m_id) ? m_data : 8'h00);
            chk("rnd_resp1_data", resp1_data, (exp_rv && m_id) ? m_data : 8'h00);
            if (exp_rv && (m_id ? resp1_ready : resp0_ready)) pend = 1'b0;
            acc0 = exp_acc && !g;
            acc1 = exp_acc && g;
            if (exp_acc) begin
                pend = 1'b1; acc_cyc = cyc; m_id = g; m_last = g;
                m_addr = g ? req1_addr : req0_addr;
                m_data = lut_fn(m_addr);
                n_txn++;
            end
            @(posedge clk); #1;
        end
        chk("rnd_enough_txns", n_txn > 100, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
